// File: rtl/circuito_gravador_pkg.sv
// Shared types and defaults for the sequence recorder: FSM state codes and size constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package circuito_gravador_pkg;

  localparam int WIDTH_PADRAO  = 4;
  localparam int ADDR_W_PADRAO = 4;
  localparam int DEPTH_PADRAO  = 16;

  // Codes are shown on the hex display, so their values are fixed.
  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    PREPARA  = 4'h1,
    ESPERA   = 4'h2,
    REGISTRA = 4'h3,
    GRAVA    = 4'h4,
    PROXIMO  = 4'h5,
    FIM      = 4'hF
  } estado_t;

endpackage

// File: rtl/circuito_gravador_if.sv
// User/compare-side signal bundle of the sequence recorder (controls, read port, debug taps).
// Latency: n/a (wiring only).
// Backpressure: none; jogada requests outside ESPERA are simply dropped by the recorder.
interface circuito_gravador_if
  import circuito_gravador_pkg::*;
#(
  parameter int WIDTH  = WIDTH_PADRAO,
  parameter int ADDR_W = ADDR_W_PADRAO
);

  logic              iniciar;
  logic              jogada;
  logic [WIDTH-1:0]  chaves;
  logic [ADDR_W-1:0] rd_endereco;
  logic [WIDTH-1:0]  rd_dado;
  logic              pronto;
  logic [ADDR_W-1:0] db_endereco;
  logic [WIDTH-1:0]  db_dado;
  logic              db_we;
  logic [3:0]        db_estado;

  // Driving side: user controls and the compare circuit's read address.
  modport master (
    output iniciar, jogada, chaves, rd_endereco,
    input  rd_dado, pronto, db_endereco, db_dado, db_we, db_estado
  );

  // Recorder side.
  modport slave (
    input  iniciar, jogada, chaves, rd_endereco,
    output rd_dado, pronto, db_endereco, db_dado, db_we, db_estado
  );

endinterface

// File: rtl/gravador_unidade_controle.sv
// Control FSM of the recorder: sequences clear, capture, write and address advance.
// Latency: outputs are registered and valid in the same cycle as the state they belong to.
// Backpressure: jogada events are only accepted in ESPERA; elsewhere they are dropped.
module gravador_unidade_controle
  import circuito_gravador_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    iniciar,
  input  logic    jogada_evt,
  input  logic    fim_c,
  output logic    zera,
  output logic    registra,
  output logic    grava,
  output logic    conta,
  output logic    pronto,
  output estado_t estado
);

  function automatic estado_t proximo_estado(estado_t e, logic ini, logic evt, logic fim);
    case (e)
      INICIAL:  return ini ? PREPARA : INICIAL;
      PREPARA:  return ESPERA;
      ESPERA:   return evt ? REGISTRA : ESPERA;
      REGISTRA: return GRAVA;
      GRAVA:    return fim ? FIM : PROXIMO;
      PROXIMO:  return ESPERA;
      FIM:      return ini ? PREPARA : FIM;
      default:  return INICIAL;
    endcase
  endfunction

  estado_t prox;
  assign prox = proximo_estado(estado, iniciar, jogada_evt, fim_c);

  // State register; each strobe is decoded from the next state so it is high exactly in its state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= INICIAL;
      zera     <= 1'b0;
      registra <= 1'b0;
      grava    <= 1'b0;
      conta    <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      estado   <= prox;
      zera     <= (prox == PREPARA);
      registra <= (prox == REGISTRA);
      grava    <= (prox == GRAVA);
      conta    <= (prox == PROXIMO);
      pronto   <= (prox == FIM);
    end
  end

endmodule

// File: rtl/ram_sync_1w1r.sv
// Synchronous RAM, one write port and one independent registered read port.
// Latency: read data 1 cycle after address; write lands on the clock edge with we=1.
// Backpressure: none; same-address read and write in one cycle returns the old word.
module ram_sync_1w1r #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_endereco,
  input  logic [WIDTH-1:0]  wr_dado,
  input  logic [ADDR_W-1:0] rd_endereco,
  output logic [WIDTH-1:0]  rd_dado
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write and registered read share the edge; the read sees the pre-write contents.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_endereco] <= wr_dado;
    end
    rd_dado <= mem[rd_endereco];
  end

endmodule

// File: rtl/circuito_gravador.sv
// Records a user-entered sequence of switch values into RAM for the compare circuit to read back.
// Latency: an accepted jogada writes RAM two cycles later; next jogada accepted >= 4 cycles after.
// Backpressure: none; jogada outside ESPERA is dropped. GRAVADOR_EDGE_DETECT_EN: rising-edge jogada.
module circuito_gravador
  import circuito_gravador_pkg::*;
#(
  parameter int WIDTH  = WIDTH_PADRAO,
  parameter int ADDR_W = ADDR_W_PADRAO,
  parameter int DEPTH  = DEPTH_PADRAO
) (
  input logic                 clock,
  input logic                 reset,
  circuito_gravador_if.slave  bus
);

  logic              zera;
  logic              registra;
  logic              grava;
  logic              conta;
  logic              pronto;
  logic              fim_c;
  logic              jogada_evt;
  estado_t           estado;
  logic [ADDR_W-1:0] contador;
  logic [WIDTH-1:0]  dado_reg;

`ifdef GRAVADOR_EDGE_DETECT_EN
  logic jogada_ant;

  // Previous jogada sample, so a held button produces a single event.
  always_ff @(posedge clock) begin
    if (!reset) begin
      jogada_ant <= 1'b0;
    end else begin
      jogada_ant <= bus.jogada;
    end
  end

  assign jogada_evt = bus.jogada & ~jogada_ant;
`else
  assign jogada_evt = bus.jogada;
`endif

  assign fim_c = (contador == ADDR_W'(DEPTH - 1));

  // Write address counter: cleared on (re)start, advanced in PROXIMO, never wraps past the last word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      contador <= '0;
    end else if (zera) begin
      contador <= '0;
    end else if (conta && !fim_c) begin
      contador <= contador + 1'b1;
    end
  end

  // Data register: captures the switches in REGISTRA and holds them through GRAVA.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dado_reg <= '0;
    end else if (zera) begin
      dado_reg <= '0;
    end else if (registra) begin
      dado_reg <= bus.chaves;
    end
  end

  gravador_unidade_controle u_controle (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (bus.iniciar),
    .jogada_evt (jogada_evt),
    .fim_c      (fim_c),
    .zera       (zera),
    .registra   (registra),
    .grava      (grava),
    .conta      (conta),
    .pronto     (pronto),
    .estado     (estado)
  );

  ram_sync_1w1r #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock       (clock),
    .we          (grava),
    .wr_endereco (contador),
    .wr_dado     (dado_reg),
    .rd_endereco (bus.rd_endereco),
    .rd_dado     (bus.rd_dado)
  );

  assign bus.pronto      = pronto;
  assign bus.db_endereco = contador;
  assign bus.db_dado     = dado_reg;
  assign bus.db_we       = grava;
  assign bus.db_estado   = estado;

endmodule

// File: tb/tb_circuito_gravador.sv
module tb_circuito_gravador;

  logic clock = 1'b0;
  logic reset = 1'b0;

  circuito_gravador_if #(.WIDTH(4), .ADDR_W(4)) bus ();

  circuito_gravador dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: recorded words and the abstract recording position.
  logic [3:0] mem_m [16];
  int         m_addr = 0;
  bit         m_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int cycles);
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    reset = 1'b0;
    idle(cycles);
    reset = 1'b1;
    m_addr = 0;
    m_done = 0;
  endtask

  task automatic start_rec();
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    check("prep_estado", bus.db_estado, 32'h1);
    tick();
    m_addr = 0;
    m_done = 0;
    check("start_estado", bus.db_estado, 32'h2);
    check("start_addr", bus.db_endereco, 32'h0);
    check("start_dado", bus.db_dado, 32'h0);
  endtask

  task automatic read_chk(input int a);
    bus.rd_endereco = 4'(a);
    tick();
    check($sformatf("ram[%0d]", a), bus.rd_dado, mem_m[a]);
  endtask

  // One jogada pulse while recording; chaves is valid for the capture and then scrambled.
  task automatic press(input logic [3:0] val, input bit collide, input bit spurious);
    bus.chaves = val;
    bus.jogada = 1'b1;
    tick();
    bus.jogada = 1'b0;
    tick();
    check("grava_estado", bus.db_estado, 32'h4);
    check("grava_we", bus.db_we, 32'h1);
    check("grava_dado", bus.db_dado, val);
    check("grava_addr", bus.db_endereco, m_addr);
    bus.chaves = 4'($urandom);
    if (collide) bus.rd_endereco = 4'(m_addr);
    if (spurious) bus.jogada = 1'b1;
    tick();
    bus.jogada = 1'b0;
    if (collide) check("coll_old", bus.rd_dado, mem_m[m_addr]);
    mem_m[m_addr] = val;
    tick();
    if (collide) check("coll_new", bus.rd_dado, val);
    check("we_off", bus.db_we, 32'h0);
    if (m_addr == 15) begin
      m_done = 1;
      check("fim_pronto", bus.pronto, 32'h1);
      check("fim_estado", bus.db_estado, 32'hF);
      check("fim_addr", bus.db_endereco, 32'hF);
    end else begin
      m_addr++;
      check("esp_estado", bus.db_estado, 32'h2);
      check("esp_addr", bus.db_endereco, m_addr);
      check("esp_pronto", bus.pronto, 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    bus.iniciar     = 1'b0;
    bus.jogada      = 1'b0;
    bus.chaves      = 4'h0;
    bus.rd_endereco = 4'h0;

    // Reset state
    do_reset(2);
    check("rst_estado", bus.db_estado, 32'h0);
    check("rst_pronto", bus.pronto, 32'h0);
    check("rst_addr", bus.db_endereco, 32'h0);
    check("rst_we", bus.db_we, 32'h0);
    check("rst_dado", bus.db_dado, 32'h0);

    // Full record of 0..F with random gaps, collisions and dropped pulses
    start_rec();
    for (int k = 0; k < 16; k++) begin
      press(4'(k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    check("full_pronto", bus.pronto, 32'h1);
    check("full_estado", bus.db_estado, 32'hF);
    for (int k = 0; k < 16; k++) read_chk(k);
    check("fim_hold_addr", bus.db_endereco, 32'hF);

    // iniciar and jogada together in FIM: restart wins, no write
    bus.iniciar = 1'b1;
    bus.jogada  = 1'b1;
    bus.chaves  = 4'h7;
    tick();
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    check("fim_ini_estado", bus.db_estado, 32'h1);
    check("fim_ini_pronto", bus.pronto, 32'h0);
    check("fim_ini_we", bus.db_we, 32'h0);
    tick();
    m_addr = 0;
    m_done = 0;
    check("fim_ini_esp", bus.db_estado, 32'h2);
    check("fim_ini_addr", bus.db_endereco, 32'h0);
    check("fim_ini_dado", bus.db_dado, 32'h0);
    idle(3);
    read_chk(15);
    read_chk(0);

    // Held jogada for 20 cycles with chaves=A
    begin
      int ready;
      ready = 0;
      for (int t = 0; t < 20; t++) begin
        bit acc;
`ifdef GRAVADOR_EDGE_DETECT_EN
        acc = (t == 0);
`else
        acc = (t >= ready);
`endif
        if (acc) begin
          mem_m[m_addr] = 4'hA;
          if (m_addr == 15) m_done = 1; else m_addr++;
          ready = t + 4;
        end
      end
    end
    bus.chaves = 4'hA;
    bus.jogada = 1'b1;
    idle(20);
    bus.jogada = 1'b0;
    idle(4);
    check("hold_estado", bus.db_estado, 32'h2);
    for (int k = 0; k < 6; k++) read_chk(k);

    // Mid-sequence abort
    do_reset(1);
    check("rst2_estado", bus.db_estado, 32'h0);
    start_rec();
    for (int k = 0; k < 5; k++) begin
      press(4'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    do_reset(1);
    check("abort_estado", bus.db_estado, 32'h0);
    check("abort_addr", bus.db_endereco, 32'h0);
    check("abort_we", bus.db_we, 32'h0);
    check("abort_dado", bus.db_dado, 32'h0);
    for (int k = 0; k < 6; k++) read_chk(k);

    // Restart from address 0, with read/write collisions on every word
    start_rec();
    for (int k = 0; k < 6; k++) begin
      press(4'($urandom), 1'b1, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    for (int k = 0; k < 8; k++) read_chk(k);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
